// File: rtl/axi_burst_splitter.sv
// Splits upstream AXI bursts into sequential single-beat transactions for a
// single-beat downstream subsystem; write and read paths run independently.
module axi_burst_splitter #(
  parameter int ID_WIDTH = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [ID_WIDTH-1:0] i_s_awid,
  input  logic [31:0]         i_s_awaddr,
  input  logic [7:0]          i_s_awlen,
  input  logic [2:0]          i_s_awsize,
  input  logic [1:0]          i_s_awburst,
  input  logic                i_s_awvalid,
  output logic                o_s_awready,
  input  logic [63:0]         i_s_wdata,
  input  logic [7:0]          i_s_wstrb,
  input  logic                i_s_wlast,
  input  logic                i_s_wvalid,
  output logic                o_s_wready,
  output logic [ID_WIDTH-1:0] o_s_bid,
  output logic [1:0]          o_s_bresp,
  output logic                o_s_bvalid,
  input  logic                i_s_bready,
  input  logic [ID_WIDTH-1:0] i_s_arid,
  input  logic [31:0]         i_s_araddr,
  input  logic [7:0]          i_s_arlen,
  input  logic [2:0]          i_s_arsize,
  input  logic [1:0]          i_s_arburst,
  input  logic                i_s_arvalid,
  output logic                o_s_arready,
  output logic [ID_WIDTH-1:0] o_s_rid,
  output logic [63:0]         o_s_rdata,
  output logic [1:0]          o_s_rresp,
  output logic                o_s_rlast,
  output logic                o_s_rvalid,
  input  logic                i_s_rready,
  output logic [ID_WIDTH-1:0] o_m_awid,
  output logic [31:0]         o_m_awaddr,
  output logic                o_m_awvalid,
  input  logic                i_m_awready,
  output logic [63:0]         o_m_wdata,
  output logic [7:0]          o_m_wstrb,
  output logic                o_m_wvalid,
  input  logic                i_m_wready,
  input  logic [1:0]          i_m_bresp,
  input  logic                i_m_bvalid,
  output logic                o_m_bready,
  output logic [ID_WIDTH-1:0] o_m_arid,
  output logic [31:0]         o_m_araddr,
  output logic                o_m_arvalid,
  input  logic                i_m_arready,
  input  logic [63:0]         i_m_rdata,
  input  logic [1:0]          i_m_rresp,
  input  logic                i_m_rvalid,
  output logic                o_m_rready,
  output logic [2:0]          o_dbg_w_state,
  output logic [1:0]          o_dbg_r_state
);

  // Every channel follows valid/ready: a beat transfers on a rising edge where
  // both are high, and a raised valid holds its payload until that edge.
  typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_RESP, W_BRSP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;

  w_state_e            w_state_q, w_state_d;
  logic [ID_WIDTH-1:0] w_id_q, w_id_d;
  logic [31:0]         w_addr_q, w_addr_d;
  logic [7:0]          w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [2:0]          w_size_q, w_size_d;
  logic [1:0]          w_burst_q, w_burst_d, w_resp_q, w_resp_d;

  r_state_e            r_state_q, r_state_d;
  logic [ID_WIDTH-1:0] r_id_q, r_id_d;
  logic [31:0]         r_addr_q, r_addr_d;
  logic [7:0]          r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [2:0]          r_size_q, r_size_d;
  logic [1:0]          r_burst_q, r_burst_d;

  logic unused_wlast;
  assign unused_wlast = i_s_wlast;

  // WRAP is honoured only for legal lengths; anything else steps like INCR.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] step, mask;
    logic        wrap_ok;
    step    = 32'd1 << size;
    mask    = (({24'd0, len} + 32'd1) << size) - 32'd1;
    wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    if (burst == 2'b00)                next_addr = addr;
    else if (burst == 2'b10 && wrap_ok) next_addr = (addr & ~mask) | ((addr + step) & mask);
    else                               next_addr = addr + step;
  endfunction

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_size_d  = w_size_q;
    w_burst_d = w_burst_q;
    w_cnt_d   = w_cnt_q;
    w_resp_d  = w_resp_q;
    case (w_state_q)
      W_IDLE: if (i_s_awvalid) begin
        w_id_d    = i_s_awid;
        w_addr_d  = i_s_awaddr;
        w_len_d   = i_s_awlen;
        w_size_d  = i_s_awsize;
        w_burst_d = i_s_awburst;
        w_cnt_d   = 8'd0;
        w_resp_d  = 2'b00;
        w_state_d = W_ADDR;
      end
      W_ADDR: if (i_m_awready) w_state_d = W_DATA;
      W_DATA: if (i_s_wvalid && i_m_wready) w_state_d = W_RESP;
      W_RESP: if (i_m_bvalid) begin
        // Worst response of the burst is what the upstream master sees.
        if (i_m_bresp > w_resp_q) w_resp_d = i_m_bresp;
        if (w_cnt_q == w_len_q) begin
          w_state_d = W_BRSP;
        end else begin
          w_cnt_d   = w_cnt_q + 8'd1;
          w_addr_d  = next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
          w_state_d = W_ADDR;
        end
      end
      W_BRSP: if (i_s_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    r_cnt_d   = r_cnt_q;
    case (r_state_q)
      R_IDLE: if (i_s_arvalid) begin
        r_id_d    = i_s_arid;
        r_addr_d  = i_s_araddr;
        r_len_d   = i_s_arlen;
        r_size_d  = i_s_arsize;
        r_burst_d = i_s_arburst;
        r_cnt_d   = 8'd0;
        r_state_d = R_ADDR;
      end
      R_ADDR: if (i_m_arready) r_state_d = R_DATA;
      R_DATA: if (i_m_rvalid && i_s_rready) begin
        if (r_cnt_q == r_len_q) begin
          r_state_d = R_IDLE;
        end else begin
          r_cnt_d   = r_cnt_q + 8'd1;
          r_addr_d  = next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
          r_state_d = R_ADDR;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_addr_q  <= 32'd0;
      w_len_q   <= 8'd0;
      w_size_q  <= 3'd0;
      w_burst_q <= 2'd0;
      w_cnt_q   <= 8'd0;
      w_resp_q  <= 2'd0;
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_addr_q  <= 32'd0;
      r_len_q   <= 8'd0;
      r_size_q  <= 3'd0;
      r_burst_q <= 2'd0;
      r_cnt_q   <= 8'd0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      w_cnt_q   <= w_cnt_d;
      w_resp_q  <= w_resp_d;
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
      r_cnt_q   <= r_cnt_d;
    end
  end

  // Handshake outputs are masked by i_rst so the reset cycle itself is quiet.
  assign o_s_awready = !i_rst && (w_state_q == W_IDLE);
  assign o_m_awvalid = !i_rst && (w_state_q == W_ADDR);
  assign o_m_awid    = w_id_q;
  assign o_m_awaddr  = w_addr_q;
  assign o_m_wvalid  = !i_rst && (w_state_q == W_DATA) && i_s_wvalid;
  assign o_s_wready  = !i_rst && (w_state_q == W_DATA) && i_m_wready;
  assign o_m_wdata   = i_s_wdata;
  assign o_m_wstrb   = i_s_wstrb;
  assign o_m_bready  = !i_rst && (w_state_q == W_RESP);
  assign o_s_bvalid  = !i_rst && (w_state_q == W_BRSP);
  assign o_s_bid     = w_id_q;
  assign o_s_bresp   = w_resp_q;

  assign o_s_arready = !i_rst && (r_state_q == R_IDLE);
  assign o_m_arvalid = !i_rst && (r_state_q == R_ADDR);
  assign o_m_arid    = r_id_q;
  assign o_m_araddr  = r_addr_q;
  assign o_s_rvalid  = !i_rst && (r_state_q == R_DATA) && i_m_rvalid;
  assign o_m_rready  = !i_rst && (r_state_q == R_DATA) && i_s_rready;
  assign o_s_rdata   = i_m_rdata;
  assign o_s_rresp   = i_m_rresp;
  assign o_s_rid     = r_id_q;
  assign o_s_rlast   = (r_state_q == R_DATA) && (r_cnt_q == r_len_q);

  assign o_dbg_w_state = w_state_q;
  assign o_dbg_r_state = r_state_q;

endmodule

// File: tb/tb_axi_burst_splitter.sv
// Directed bench for axi_burst_splitter: upstream master tasks, a downstream
// responder loop, queues of observed beats and hand-computed expectations.
module tb_axi_burst_splitter;
  localparam int IDW = 2;

  logic clk, i_rst;
  logic [IDW-1:0] i_s_awid, i_s_arid;
  logic [31:0] i_s_awaddr, i_s_araddr;
  logic [7:0]  i_s_awlen, i_s_arlen, i_s_wstrb;
  logic [2:0]  i_s_awsize, i_s_arsize;
  logic [1:0]  i_s_awburst, i_s_arburst, i_m_bresp, i_m_rresp;
  logic        i_s_awvalid, i_s_wlast, i_s_wvalid, i_s_bready, i_s_arvalid, i_s_rready;
  logic [63:0] i_s_wdata, i_m_rdata;
  logic        i_m_awready, i_m_wready, i_m_bvalid, i_m_arready, i_m_rvalid;
  logic        o_s_awready, o_s_wready, o_s_bvalid, o_s_arready, o_s_rlast, o_s_rvalid;
  logic [IDW-1:0] o_s_bid, o_s_rid, o_m_awid, o_m_arid;
  logic [1:0]  o_s_bresp, o_s_rresp;
  logic [63:0] o_s_rdata, o_m_wdata;
  logic [31:0] o_m_awaddr, o_m_araddr;
  logic [7:0]  o_m_wstrb;
  logic        o_m_awvalid, o_m_wvalid, o_m_bready, o_m_arvalid, o_m_rready;
  logic [2:0]  o_dbg_w_state;
  logic [1:0]  o_dbg_r_state;

  axi_burst_splitter #(.ID_WIDTH(IDW)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_s_awid(i_s_awid), .i_s_awaddr(i_s_awaddr), .i_s_awlen(i_s_awlen),
    .i_s_awsize(i_s_awsize), .i_s_awburst(i_s_awburst), .i_s_awvalid(i_s_awvalid),
    .o_s_awready(o_s_awready),
    .i_s_wdata(i_s_wdata), .i_s_wstrb(i_s_wstrb), .i_s_wlast(i_s_wlast),
    .i_s_wvalid(i_s_wvalid), .o_s_wready(o_s_wready),
    .o_s_bid(o_s_bid), .o_s_bresp(o_s_bresp), .o_s_bvalid(o_s_bvalid), .i_s_bready(i_s_bready),
    .i_s_arid(i_s_arid), .i_s_araddr(i_s_araddr), .i_s_arlen(i_s_arlen),
    .i_s_arsize(i_s_arsize), .i_s_arburst(i_s_arburst), .i_s_arvalid(i_s_arvalid),
    .o_s_arready(o_s_arready),
    .o_s_rid(o_s_rid), .o_s_rdata(o_s_rdata), .o_s_rresp(o_s_rresp), .o_s_rlast(o_s_rlast),
    .o_s_rvalid(o_s_rvalid), .i_s_rready(i_s_rready),
    .o_m_awid(o_m_awid), .o_m_awaddr(o_m_awaddr), .o_m_awvalid(o_m_awvalid),
    .i_m_awready(i_m_awready),
    .o_m_wdata(o_m_wdata), .o_m_wstrb(o_m_wstrb), .o_m_wvalid(o_m_wvalid), .i_m_wready(i_m_wready),
    .i_m_bresp(i_m_bresp), .i_m_bvalid(i_m_bvalid), .o_m_bready(o_m_bready),
    .o_m_arid(o_m_arid), .o_m_araddr(o_m_araddr), .o_m_arvalid(o_m_arvalid),
    .i_m_arready(i_m_arready),
    .i_m_rdata(i_m_rdata), .i_m_rresp(i_m_rresp), .i_m_rvalid(i_m_rvalid), .o_m_rready(o_m_rready),
    .o_dbg_w_state(o_dbg_w_state), .o_dbg_r_state(o_dbg_r_state)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] aw_got[$], ar_got[$];
  logic [71:0] w_got[$];
  logic [63:0] r_got[$];
  logic [4:0]  rl_got[$];
  logic [3:0]  ub_got[$];
  logic [1:0]  bresp_tab[$];
  logic [IDW-1:0] exp_aw_id, exp_ar_id;
  int b_idx = 0, r_idx = 0, b_pending = 0, r_pending = 0;
  bit stall = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic rnd();
    return stall ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  // ---------------- downstream responder + monitors ----------------
  initial begin
    logic aw_hs, ar_hs, w_hs, b_hs, r_hs;
    logic aw_hold, ar_hold, w_hold;
    logic [31:0] aw_prev, ar_prev;
    logic [71:0] w_prev;
    {aw_hs, ar_hs, w_hs, b_hs, r_hs, aw_hold, ar_hold, w_hold} = '0;
    aw_prev = '0; ar_prev = '0; w_prev = '0;
    forever begin
      @(posedge clk); #1;
      if (b_hs) i_m_bvalid = 1'b0;
      if (r_hs) i_m_rvalid = 1'b0;
      i_m_awready = rnd(); i_m_wready = rnd(); i_m_arready = rnd();
      i_s_bready  = rnd(); i_s_rready = rnd();
      if (!i_m_bvalid && b_pending > 0 && rnd()) begin
        i_m_bvalid = 1'b1;
        i_m_bresp  = (b_idx < bresp_tab.size()) ? bresp_tab[b_idx] : 2'b00;
      end
      if (!i_m_rvalid && r_pending > 0 && rnd()) begin
        i_m_rvalid = 1'b1;
        i_m_rdata  = 64'hD00D_0000_0000_0000 | 64'(r_idx);
        i_m_rresp  = 2'(r_idx);
      end
      @(negedge clk);
      aw_hs = o_m_awvalid && i_m_awready;
      ar_hs = o_m_arvalid && i_m_arready;
      w_hs  = o_m_wvalid && i_m_wready;
      b_hs  = o_m_bready && i_m_bvalid;
      r_hs  = o_m_rready && i_m_rvalid;
      if (aw_hold) check("aw_hold", {o_m_awvalid, o_m_awaddr}, {1'b1, aw_prev});
      if (ar_hold) check("ar_hold", {o_m_arvalid, o_m_araddr}, {1'b1, ar_prev});
      if (w_hold)  check("w_hold", {o_m_wvalid, o_m_wstrb, o_m_wdata}, {1'b1, w_prev});
      aw_hold = o_m_awvalid && !i_m_awready; aw_prev = o_m_awaddr;
      ar_hold = o_m_arvalid && !i_m_arready; ar_prev = o_m_araddr;
      w_hold  = o_m_wvalid && !i_m_wready;   w_prev  = {o_m_wstrb, o_m_wdata};
      if (aw_hs) begin
        aw_got.push_back(o_m_awaddr);
        check("aw_id", o_m_awid, exp_aw_id);
      end
      if (ar_hs) begin
        ar_got.push_back(o_m_araddr);
        check("ar_id", o_m_arid, exp_ar_id);
        r_pending++;
      end
      if (w_hs) begin
        w_got.push_back({o_m_wstrb, o_m_wdata});
        b_pending++;
      end
      if (b_hs) begin
        b_pending--;
        b_idx++;
      end
      if (r_hs) begin
        r_pending--;
        r_idx++;
      end
      if (o_s_bvalid && i_s_bready) ub_got.push_back({o_s_bid, o_s_bresp});
      if (o_s_rvalid && i_s_rready) begin
        r_got.push_back(o_s_rdata);
        rl_got.push_back({o_s_rid, o_s_rlast, o_s_rresp});
      end
    end
  end

  // ---------------- upstream driver tasks ----------------
  task automatic send_aw(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    @(posedge clk); #1;
    i_s_awid = id; i_s_awaddr = addr; i_s_awlen = len; i_s_awsize = size; i_s_awburst = burst;
    i_s_awvalid = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (o_s_awready) break;
    end
    check("aw_accept", o_s_awready, 1'b1);
    @(posedge clk); #1;
    i_s_awvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    @(posedge clk); #1;
    i_s_arid = id; i_s_araddr = addr; i_s_arlen = len; i_s_arsize = size; i_s_arburst = burst;
    i_s_arvalid = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (o_s_arready) break;
    end
    check("ar_accept", o_s_arready, 1'b1);
    @(posedge clk); #1;
    i_s_arvalid = 1'b0;
  endtask

  task automatic send_w(input int beats, input logic [63:0] base);
    for (int i = 0; i < beats; i++) begin
      @(posedge clk); #1;
      if (stall) begin
        i_s_wvalid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      i_s_wvalid = 1'b1;
      i_s_wdata  = base + 64'(i);
      i_s_wstrb  = 8'hF0 | 8'(i);
      i_s_wlast  = (i == beats - 1);
      for (int n = 0; n < 400; n++) begin
        @(negedge clk);
        if (o_s_wready) break;
      end
      check("w_accept", o_s_wready, 1'b1);
    end
    @(posedge clk); #1;
    i_s_wvalid = 1'b0;
  endtask

  task automatic wait_b(input int n);
    for (int k = 0; k < 3000 && ub_got.size() < n; k++) begin @(negedge clk); #1; end
    check("b_count", ub_got.size(), n);
  endtask

  task automatic wait_r(input int n);
    for (int k = 0; k < 3000 && r_got.size() < n; k++) begin @(negedge clk); #1; end
    check("r_count", r_got.size(), n);
  endtask

  task automatic clear_sb();
    aw_got.delete(); ar_got.delete(); w_got.delete();
    r_got.delete(); rl_got.delete(); ub_got.delete();
    b_idx = 0;
  endtask

  task automatic check_aw(input string tag, input logic [31:0] exp[], input logic [63:0] base);
    check({tag, "_aw_n"}, aw_got.size(), exp.size());
    for (int k = 0; k < exp.size(); k++) begin
      check($sformatf("%s_aw%0d", tag, k), aw_got[k], exp[k]);
      check($sformatf("%s_w%0d", tag, k), w_got[k], {8'hF0 | 8'(k), base + 64'(k)});
    end
  endtask

  task automatic check_ar(input string tag, input logic [31:0] exp[], input int rbase,
                          input logic [IDW-1:0] id);
    check({tag, "_ar_n"}, ar_got.size(), exp.size());
    for (int k = 0; k < exp.size(); k++) begin
      check($sformatf("%s_ar%0d", tag, k), ar_got[k], exp[k]);
      check($sformatf("%s_rd%0d", tag, k), r_got[k], 64'hD00D_0000_0000_0000 | 64'(rbase + k));
      check($sformatf("%s_rl%0d", tag, k), rl_got[k],
            {id, 1'(k == exp.size() - 1), 2'(rbase + k)});
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int rbase;
    logic [31:0] e4[], e3[], e2[];
    i_rst = 1'b1;
    {i_s_awid, i_s_awaddr, i_s_awlen, i_s_awsize, i_s_awburst, i_s_awvalid} = '0;
    {i_s_arid, i_s_araddr, i_s_arlen, i_s_arsize, i_s_arburst, i_s_arvalid} = '0;
    {i_s_wdata, i_s_wstrb, i_s_wlast, i_s_wvalid, i_s_bready, i_s_rready} = '0;
    {i_m_awready, i_m_wready, i_m_bresp, i_m_bvalid, i_m_arready} = '0;
    {i_m_rdata, i_m_rresp, i_m_rvalid} = '0;
    exp_aw_id = '0; exp_ar_id = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_quiet", {o_m_awvalid, o_m_wvalid, o_m_bready, o_s_bvalid,
                        o_m_arvalid, o_m_rready, o_s_rvalid, o_s_wready}, 8'h00);
    @(posedge clk); #2;
    i_rst = 1'b0;
    @(negedge clk);
    check("rst_awready", o_s_awready, 1'b1);
    check("rst_arready", o_s_arready, 1'b1);
    check("rst_states", {o_dbg_w_state, o_dbg_r_state}, 5'd0);

    // INCR write, 4 beats of 8 bytes, all OKAY
    clear_sb(); bresp_tab = '{2'd0, 2'd0, 2'd0, 2'd0}; exp_aw_id = 2'd1;
    fork
      send_aw(2'd1, 32'h100, 8'd3, 3'd3, 2'b01);
      send_w(4, 64'h1111_0000_0000_0000);
    join
    wait_b(1);
    repeat (5) @(posedge clk);
    e4 = '{32'h100, 32'h108, 32'h110, 32'h118};
    check_aw("incr_wr", e4, 64'h1111_0000_0000_0000);
    check("incr_wr_b", ub_got[0], {2'd1, 2'b00});
    check("incr_wr_bn", ub_got.size(), 1);

    // WRAP read from the last slot of a 32-byte window
    clear_sb(); exp_ar_id = 2'd2; rbase = r_idx;
    send_ar(2'd2, 32'h118, 8'd3, 3'd3, 2'b10);
    wait_r(4);
    e4 = '{32'h118, 32'h100, 32'h108, 32'h110};
    check_ar("wrap_rd", e4, rbase, 2'd2);

    // FIXED read
    clear_sb(); exp_ar_id = 2'd3; rbase = r_idx;
    send_ar(2'd3, 32'h8, 8'd2, 3'd3, 2'b00);
    wait_r(3);
    e3 = '{32'h8, 32'h8, 32'h8};
    check_ar("fixed_rd", e3, rbase, 2'd3);

    // WRAP with illegal length and reserved burst both step like INCR
    clear_sb(); exp_ar_id = 2'd1; rbase = r_idx;
    send_ar(2'd1, 32'h30, 8'd2, 3'd2, 2'b10);
    wait_r(3);
    e3 = '{32'h30, 32'h34, 32'h38};
    check_ar("wrap_len2", e3, rbase, 2'd1);
    clear_sb(); rbase = r_idx;
    send_ar(2'd1, 32'h40, 8'd1, 3'd2, 2'b11);
    wait_r(2);
    e2 = '{32'h40, 32'h44};
    check_ar("rsvd_burst", e2, rbase, 2'd1);

    // Error on the middle beat survives to the final response
    clear_sb(); bresp_tab = '{2'd0, 2'd2, 2'd0}; exp_aw_id = 2'd2;
    fork
      send_aw(2'd2, 32'h200, 8'd2, 3'd2, 2'b01);
      send_w(3, 64'h2222_0000_0000_0000);
    join
    wait_b(1);
    e3 = '{32'h200, 32'h204, 32'h208};
    check_aw("err_wr", e3, 64'h2222_0000_0000_0000);
    check("err_wr_b", ub_got[0], {2'd2, 2'b10});

    // INCR crossing the top of the address space; larger code (3) retained
    clear_sb(); bresp_tab = '{2'd3, 2'd1}; exp_aw_id = 2'd0;
    fork
      send_aw(2'd0, 32'hFFFF_FFF8, 8'd1, 3'd3, 2'b01);
      send_w(2, 64'h3333_0000_0000_0000);
    join
    wait_b(1);
    e2 = '{32'hFFFF_FFF8, 32'h0000_0000};
    check_aw("top_wr", e2, 64'h3333_0000_0000_0000);
    check("top_wr_b", ub_got[0], {2'd0, 2'b11});

    // Concurrent write and read with random stalls everywhere
    clear_sb(); bresp_tab = '{2'd0, 2'd0, 2'd0, 2'd0};
    exp_aw_id = 2'd3; exp_ar_id = 2'd0; rbase = r_idx; stall = 1;
    fork
      send_aw(2'd3, 32'h300, 8'd3, 3'd3, 2'b01);
      send_w(4, 64'h4444_0000_0000_0000);
      send_ar(2'd0, 32'h404, 8'd3, 3'd2, 2'b10);
    join
    wait_b(1);
    wait_r(4);
    stall = 0;
    repeat (10) @(posedge clk);
    e4 = '{32'h300, 32'h308, 32'h310, 32'h318};
    check_aw("conc_wr", e4, 64'h4444_0000_0000_0000);
    check("conc_wr_b", ub_got[0], {2'd3, 2'b00});
    check("conc_wr_bn", ub_got.size(), 1);
    e4 = '{32'h404, 32'h408, 32'h40C, 32'h400};
    check_ar("conc_rd", e4, rbase, 2'd0);
    check("conc_rd_n", r_got.size(), 4);

    // Reset during beat 2 of a 4-beat write, then a clean single-beat write
    clear_sb(); bresp_tab = '{2'd0, 2'd0, 2'd0, 2'd0}; exp_aw_id = 2'd1;
    @(posedge clk); #1;
    i_s_wvalid = 1'b1; i_s_wdata = 64'h5555; i_s_wstrb = 8'hFF; i_s_wlast = 1'b0;
    send_aw(2'd1, 32'h500, 8'd3, 3'd3, 2'b01);
    for (int k = 0; k < 400 && aw_got.size() < 2; k++) begin @(negedge clk); #1; end
    check("mid_aw_n", aw_got.size(), 2);
    @(posedge clk); #2;
    i_rst = 1'b1; i_s_wvalid = 1'b0;
    @(negedge clk);
    check("mid_rst_quiet", {o_m_awvalid, o_m_wvalid, o_m_bready, o_s_bvalid,
                            o_m_arvalid, o_m_rready, o_s_rvalid, o_s_wready}, 8'h00);
    @(posedge clk); #2;
    i_rst = 1'b0; b_pending = 0; r_pending = 0; i_m_bvalid = 1'b0; i_m_rvalid = 1'b0;
    @(negedge clk);
    check("mid_awready", o_s_awready, 1'b1);
    check("mid_state", o_dbg_w_state, 3'd0);
    check("mid_valids", {o_m_awvalid, o_m_wvalid, o_s_bvalid}, 3'b000);
    check("mid_w_n", w_got.size(), 1);
    check("mid_b_n", ub_got.size(), 0);
    clear_sb(); bresp_tab = '{2'd0}; exp_aw_id = 2'd2;
    fork
      send_aw(2'd2, 32'h600, 8'd0, 3'd3, 2'b01);
      send_w(1, 64'h6666_0000_0000_0000);
    join
    wait_b(1);
    e2 = new[1];
    e2[0] = 32'h600;
    check_aw("post_rst", e2, 64'h6666_0000_0000_0000);
    check("post_rst_b", ub_got[0], {2'd2, 2'b00});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
